// File: rtl/outport_rr_allocator_pkg.sv
// Shared definitions for the per-output switch allocators of the 5-port router.
package outport_rr_allocator_pkg;

    localparam int NPORTS      = 5;
    localparam int PW          = $clog2(NPORTS);
    localparam int CREDITS_DEF = 4;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Index of the set bit of a one-hot vector (zero for an all-zero vector).
    function automatic logic [PW-1:0] onehot_idx(input logic [NPORTS-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (oh[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    // Port index plus one, wrapping back to port 0 after the last port.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (i == PW'(NPORTS - 1)) ? '0 : i + PW'(1);
    endfunction

endpackage

// File: rtl/outport_rr_allocator_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          valid_o
);

    // Scan N positions starting at ptr; the first hit wins, so pick is one-hot.
    always_comb begin
        logic found;
        int   idx;
        pick_o = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/outport_rr_allocator.sv
// Output-port switch allocator: round-robin packet lock with credit-gated transfer.
module outport_rr_allocator
    import outport_rr_allocator_pkg::*;
#(
    parameter  int CREDITS = CREDITS_DEF,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NPORTS-1:0] req_i,
    input  logic [NPORTS-1:0] tail_i,
    input  logic              credit_in_i,
    output logic [NPORTS-1:0] grant_o,
    output logic              fire_o,
    output logic [CW-1:0]     credit_cnt_o,
    output logic              busy_o,
    output logic              credit_err_o
);

    state_e            state_q;
    logic [NPORTS-1:0] grant_q;
    logic              busy_q;
    logic [PW-1:0]     ptr_q;
    logic [CW-1:0]     credit_q, credit_d;
    logic              err_q, err_d;

    logic [NPORTS-1:0] pick;
    logic              pick_valid;
    logic              own_req;
    logic              own_tail;
    logic              fire;

    rr_pick #(
        .N  (NPORTS),
        .PW (PW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    // grant_q is zero or one-hot, so masking and OR-reducing selects the owner's bits.
    assign own_req  = |(req_i & grant_q);
    assign own_tail = |(tail_i & grant_q);
    assign fire     = (state_q == ST_LOCKED) && own_req && (credit_q != '0);

    // Arbitrate in IDLE, hold the owner through its tail, then advance the pointer past it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (fire && own_tail) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= wrap_inc(onehot_idx(grant_q));
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Credit bookkeeping: a transfer consumes a slot, a returned credit restores one.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (fire && !credit_in_i) begin
            credit_d = credit_q - CW'(1);
        end else if (!fire && credit_in_i) begin
            if (credit_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    // Credit counter and sticky overflow flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= CW'(CREDITS);
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign grant_o      = grant_q;
    assign fire_o       = fire;
    assign credit_cnt_o = credit_q;
    assign busy_o       = busy_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_outport_rr_allocator.sv
// Directed bench for outport_rr_allocator with a packet-level reference model.
module tb_outport_rr_allocator;
    import outport_rr_allocator_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       cin = 1'b0;
    logic [4:0] grant;
    logic       fire;
    logic [2:0] cred;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Model state: owning input (-1 = none), next-search start, credits, sticky error.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cred  = 4;
    bit m_err   = 1'b0;

    logic [4:0] rot [12] = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100, 5'b00000,
                             5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00000};

    outport_rr_allocator dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .tail_i       (tail),
        .credit_in_i  (cin),
        .grant_o      (grant),
        .fire_o       (fire),
        .credit_cnt_o (cred),
        .busy_o       (busy),
        .credit_err_o (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle: compare DUT against the model, then advance the model by one clock.
    always @(negedge clk) begin : mdl
        bit ef;
        int eg;
        int nxt;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cred  = 4;
            m_err   = 1'b0;
        end
        ef = (m_owner >= 0) && req[m_owner] && (m_cred > 0);
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("model_grant", int'(grant), eg);
        chk("model_busy", int'(busy), int'(m_owner >= 0));
        chk("model_fire", int'(fire), int'(ef));
        chk("model_credit", int'(cred), m_cred);
        chk("model_err", int'(err), int'(m_err));
        if (rst_n) begin
            if (m_owner < 0) begin
                for (int k = 0; k < 5; k++) begin
                    nxt = (m_ptr + k) % 5;
                    if (m_owner < 0 && req[nxt]) m_owner = nxt;
                end
            end else if (ef && tail[m_owner]) begin
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
            end
            if (ef && !cin) m_cred = m_cred - 1;
            else if (!ef && cin) begin
                if (m_cred == 4) m_err = 1'b1;
                else m_cred = m_cred + 1;
            end
        end
    end

    initial begin
        tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_credit", int'(cred), 4);
        chk("rst_err", int'(err), 0);
        tick();
        rst_n = 1'b1;

        // Single packet drains all credits and stalls with the lock held.
        req = 5'b00100;
        tick();
        chk("t1_grant_latency", int'(grant), 'b00100);
        chk("t1_busy", int'(busy), 1);
        chk("t1_fire", int'(fire), 1);
        repeat (4) tick();
        chk("t1_held_grant", int'(grant), 'b00100);
        chk("t1_credit_zero", int'(cred), 0);
        chk("t1_no_fire", int'(fire), 0);

        // One credit returned allows one flit; tail releases and pointer moves to 3.
        cin = 1'b1;
        tick();
        cin = 1'b0;
        chk("t2_credit_one", int'(cred), 1);
        chk("t2_fire", int'(fire), 1);
        tail = 5'b00100;
        tick();
        tail = '0;
        chk("t2_release_grant", int'(grant), 0);
        chk("t2_release_busy", int'(busy), 0);
        chk("t2_credit", int'(cred), 0);
        req = 5'b11111;
        tick();
        chk("t2_ptr_is_3", int'(grant), 'b01000);
        req = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Single-flit packets from all inputs rotate with a bubble between grants.
        req  = 5'b11111;
        tail = 5'b11111;
        cin  = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            chk($sformatf("t3_rot%0d", j), int'(grant), int'(rot[j]));
        end
        req  = '0;
        tail = '0;
        cin  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Wormhole lock: owner drops its request, another input is ignored.
        req = 5'b00010;
        tick();
        tick();
        req = 5'b01000;
        repeat (3) begin
            tick();
            chk("t4_lock_grant", int'(grant), 'b00010);
            chk("t4_lock_nofire", int'(fire), 0);
        end
        chk("t4_lock_credit", int'(cred), 3);
        req = 5'b00010;
        #1;
        chk("t4_resume_fire", int'(fire), 1);
        tick();
        chk("t4_credit_two", int'(cred), 2);

        // Asynchronous reset mid-packet takes effect without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", int'(grant), 0);
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_credit", int'(cred), 4);
        chk("t5_async_fire", int'(fire), 0);
        req = '0;
        tick();
        rst_n = 1'b1;

        // Credit overflow is sticky; fire together with a credit return nets zero.
        cin = 1'b1;
        tick();
        cin = 1'b0;
        chk("t6_sat_credit", int'(cred), 4);
        chk("t6_err_set", int'(err), 1);
        tick();
        chk("t6_err_sticky", int'(err), 1);
        req = 5'b10001;
        tick();
        chk("t6_ptr_reset_0", int'(grant), 'b00001);
        tick();
        chk("t6_credit_three", int'(cred), 3);
        cin = 1'b1;
        tick();
        cin = 1'b0;
        chk("t6_fire_and_credit", int'(cred), 3);
        tick();
        chk("t6_credit_after", int'(cred), 2);
        chk("t6_err_still", int'(err), 1);
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/outport_rr_allocator.md
Name: outport_rr_allocator

Overview:
- Per-output-port switch allocator for the 5-port wormhole router.
- Sits directly upstream of the output-port priority selector and crossbar mux.
- Arbitrates round-robin among the 5 input ports requesting this output and holds the grant for the whole packet, up to and including the tail flit.
- Gates flit transfer on downstream credits and drives the one-hot grant lines (gX0..gX4) consumed by the selector.

Parameters:
- NPORTS, 5, number of input ports competing for this output.
- CREDITS, 4, downstream buffer depth in flits; also the credit counter reset value.
- CW, 3, credit counter width; must hold CREDITS (localparam, derived).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NPORTS  req[i]=1: input i has a flit at its head routed to this output.
- tail  in  NPORTS  tail[i]=1: the flit presented by input i is a tail (single-flit packet: head=tail).
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot.
- grant  out  NPORTS  one-hot owner of this output; all-zero when idle; drives the selector's g inputs.
- fire  out  1  a flit transfers this cycle from the granted input.
- credit_cnt  out  CW  current available downstream credits.
- busy  out  1  1 while a packet holds the output (state LOCKED).
- credit_err  out  1  sticky: credit_in received while credit_cnt==CREDITS.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant=0, fire=0, busy=0.
  - rr pointer=0.
  - credit_cnt=CREDITS, credit_err=0.
  - Reset mid-packet abandons the lock with no further transfers.
- States: IDLE, LOCKED.
- IDLE:
  - If req!=0, pick the first set req[i] scanning from index ptr upward, wrapping mod NPORTS.
  - Register grant=onehot(i), busy=1, state=LOCKED on the next edge.
  - Request-to-grant latency is 1 cycle.
  - fire=0 in IDLE.
  - Arbitration ignores credits.
- LOCKED, owner o:
  - fire = req[o] & (credit_cnt!=0), combinational from registered state and inputs.
  - grant holds unchanged while req[o]=0 (wormhole lock); no fire in that case.
  - Requests from other inputs are ignored until release.
  - On fire & tail[o]:
    - Next edge: grant=0, busy=0, state=IDLE, ptr=(o+1) mod NPORTS.
    - A new packet gets its grant no earlier than 2 cycles after the tail fire (one-cycle IDLE bubble by design).
- grant is always zero or exactly one-hot; never X; never multi-hot.
- Credit counter, per cycle:
  - fire only: decrement.
  - credit_in only: increment.
  - Both: unchanged.
  - fire cannot occur at 0, so no underflow.
  - credit_in at CREDITS with no fire: count saturates and credit_err is set and stays set until reset.
- All outputs except fire are registered.

Decomposition:
- Shared package router_pkg:
  - NPORTS.
  - Port index constants P0..P4.
  - Default CREDITS.
  - State encoding constants ST_IDLE / ST_LOCKED.
- One natural sub-module: rr_pick.
  - Combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: one-hot pick and valid.
  - Reusable by the other four output allocators.

Test Plan:
- Reset, then req=5'b00100 with tail=0 -> grant=5'b00100 and busy=1 one cycle later; fire=1 each cycle while credit_cnt>0; after 4 fires with no credit_in, credit_cnt=0 and fire=0 with grant held.
- From the previous state, pulse credit_in once -> credit_cnt=1, fire=1 for one cycle; then assert tail[2] on a fire -> next cycle grant=0, busy=0, ptr=3.
- req=5'b11111 with single-flit packets (tail=all 1s) and credit_in returned each cycle -> grants rotate in order 00001, 00010, 00100, 01000, 10000, 00001 with a one-cycle gap between each.
- While locked to input 1 (req=5'b00010), drop req[1] for 3 cycles and raise req[3] -> grant stays 00010, fire=0; restore req[1] -> transfers resume.
- Assert rst=0 mid-packet at credit_cnt=2 -> grant=0, busy=0, credit_cnt=4, ptr=0 immediately without waiting for a clock edge.
- Pulse credit_in at credit_cnt=4 with no fire -> credit_cnt stays 4, credit_err=1 and stays 1; simultaneous fire and credit_in at credit_cnt=3 -> stays 3.
